// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32I decode constants and immediate-format classification for the ID stage.
package id_stage_pipe_pkg;

  localparam int PC_WIDTH_DEF = 10;

  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J_JAL   = 7'b1101111;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_I_IMM   = 7'b0010011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_FENCE = 7'b0001111;
  localparam logic [6:0] OP_I_CSR   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Shift-immediates (funct3 001/101) carry a 5-bit shamt, not a signed I immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] op, input logic [2:0] f3);
    imm_type_e t;
    t = IMM_NONE;
    case (op)
      OP_U_LUI, OP_U_AUIPC: t = IMM_U;
      OP_J_JAL:             t = IMM_J;
      OP_I_JALR, OP_I_LOAD: t = IMM_I;
      OP_I_IMM:             t = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
      OP_B:                 t = IMM_B;
      OP_S:                 t = IMM_S;
      default:              t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/id_stage_pipe_imm_gen.sv
// Combinational immediate generator: instruction word to sign-extended immediate.
module id_stage_pipe_imm_gen
  import id_stage_pipe_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  imm_type_e imm_type;

  assign imm_type = imm_type_of(inst[6:0], inst[14:12]);

  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
      IMM_SHAMT: imm = {27'd0, inst[24:20]};
      IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     imm = {inst[31:12], 12'd0};
      IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:   imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: decode, operand forwarding, load-use interlock and ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter bit FWD_EN    = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                id_ready,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [31:0]         id_inst,
  input  logic                flush,
  output logic                rs1_re,
  output logic                rs2_re,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  input  logic [31:0]         rs1_data_i,
  input  logic [31:0]         rs2_data_i,
  input  logic                ex_fwd_we,
  input  logic [4:0]          ex_fwd_addr,
  input  logic [31:0]         ex_fwd_data,
  input  logic                wb_fwd_we,
  input  logic [4:0]          wb_fwd_addr,
  input  logic [31:0]         wb_fwd_data,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [PC_WIDTH-1:0] ex_pc,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic [6:0]          ex_funct7,
  output logic [31:0]         ex_imm,
  output logic [31:0]         ex_rs1_data,
  output logic [31:0]         ex_rs2_data,
  output logic                ex_rd_we,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_is_load,
  output logic                ex_illegal
);

  logic [6:0]  opcode;
  logic [31:0] imm;
  logic        rd_we;
  logic        illegal;
  logic [4:0]  rd_addr;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hazard;
  logic        adv;
  logic        xfer;

  assign opcode = id_inst[6:0];

  id_stage_pipe_imm_gen u_imm_gen (
    .inst (id_inst),
    .imm  (imm)
  );

  always_comb begin
    rs1_re  = 1'b0;
    rs2_re  = 1'b0;
    rd_we   = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_U_LUI, OP_U_AUIPC, OP_J_JAL: rd_we = 1'b1;
      OP_I_JALR, OP_I_LOAD, OP_I_IMM: begin
        rs1_re = 1'b1;
        rd_we  = 1'b1;
      end
      OP_S, OP_B: begin
        rs1_re = 1'b1;
        rs2_re = 1'b1;
      end
      OP_R: begin
        rs1_re = 1'b1;
        rs2_re = 1'b1;
        rd_we  = 1'b1;
      end
      OP_I_FENCE, OP_I_CSR: ;
      default: illegal = 1'b1;
    endcase
  end

  assign rs1_addr = rs1_re ? id_inst[19:15] : 5'd0;
  assign rs2_addr = rs2_re ? id_inst[24:20] : 5'd0;
  assign rd_addr  = rd_we  ? id_inst[11:7]  : 5'd0;

  // x0 reads as zero; the younger EX result wins over WB, WB over the regfile.
  function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rf);
    logic [31:0] d;
    d = rf;
    if (addr == 5'd0) d = 32'd0;
    else if (FWD_EN && ex_fwd_we && ex_fwd_addr == addr) d = ex_fwd_data;
    else if (FWD_EN && wb_fwd_we && wb_fwd_addr == addr) d = wb_fwd_data;
    return d;
  endfunction

  assign op1 = operand(rs1_addr, rs1_data_i);
  assign op2 = operand(rs2_addr, rs2_data_i);

  assign hazard = HAZARD_EN && ex_valid && ex_is_load && (ex_rd_addr != 5'd0) &&
                  ((rs1_re && rs1_addr == ex_rd_addr) || (rs2_re && rs2_addr == ex_rd_addr));

  // Handshake: the register advances when empty or drained by EX (adv); ID accepts
  // when it can advance and no load-use hazard is pending; a transfer is if_valid && id_ready.
  assign adv      = !ex_valid || ex_ready;
  assign id_ready = adv && !hazard;
  assign xfer     = if_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_opcode   <= 7'd0;
      ex_funct3   <= 3'd0;
      ex_funct7   <= 7'd0;
      ex_imm      <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_rd_we    <= 1'b0;
      ex_rd_addr  <= 5'd0;
      ex_is_load  <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid <= if_valid && !hazard;
      if (xfer) begin
        ex_pc       <= pc_i;
        ex_opcode   <= opcode;
        ex_funct3   <= id_inst[14:12];
        ex_funct7   <= id_inst[31:25];
        ex_imm      <= imm;
        ex_rs1_data <= op1;
        ex_rs2_data <= op2;
        ex_rd_we    <= rd_we;
        ex_rd_addr  <= rd_addr;
        ex_is_load  <= (opcode == OP_I_LOAD);
        ex_illegal  <= illegal;
      end
    end
  end

endmodule
